i2c_byte_responder: RTL
=======================

# i2c_byte_responder

Target-side byte transmitter for the EPT I2C slave testbench and RTL. It answers a controller-driven read: it presents one loaded byte MSB-first on SDA, changing data only while SCLK is low, then releases SDA and samples the controller's ACK/NACK on the 9th clock. SCLK arrives asynchronously from the bus and is synchronized into the CLK domain. SDA is driven open-drain through an output-enable. It sits between the slave register file, which supplies DIN/LOAD, and the SDA pad.

## Interface
- SYNC_STAGES, 2, number of flops in the SCLK/SDA_IN synchronizers (legal range 2..4).
- CLK  in  1  system clock; all logic is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- LOAD  in  1  one-cycle request to transmit DIN; accepted only in IDLE.
- DIN  in  8  byte to transmit; captured on the accepted LOAD cycle.
- ABORT  in  1  STOP/bus-error indication from the slave controller; cancels the transfer.
- SCLK_IN  in  1  bus clock, asynchronous.
- SDA_IN  in  1  bus data as seen at the pad, asynchronous.
- SDA_OE  out  1  1 = pull SDA low, 0 = release (high-Z).
- BUSY  out  1  high from the cycle after an accepted LOAD until the cycle after DONE or ABORT.
- DONE  out  1  one-cycle pulse at the end of the ACK bit.
- ACK  out  1  valid on DONE and held until the next accepted LOAD: 1 = controller drove ACK (SDA low), 0 = NACK.
- OVERRUN  out  1  one-cycle pulse when LOAD arrives while BUSY; the LOAD is ignored.

## Operation
- Reset values: SDA_OE=0, BUSY=0, DONE=0, ACK=0, OVERRUN=0, state IDLE, bit counter 0, shift register 0.
- SCLK synchronizer: a SYNC_STAGES flop chain plus one history flop. `rise` and `fall` are single-cycle pulses derived from the synchronized level `sclk_s`. SDA_IN uses an identical chain to produce `sda_s`.
- State machine (one-hot):
  - IDLE: on LOAD, capture DIN into the shift register and clear bit_cnt. If sclk_s=1, go to WAIT_LOW; otherwise go to DRIVE.
  - WAIT_LOW: stay until `fall`, then go to DRIVE.
  - DRIVE: set SDA_OE = ~shift[7], then go to WAIT_RISE.
  - WAIT_RISE: on `rise`, go to WAIT_FALL.
  - WAIT_FALL: on `fall`:
    - If bit_cnt=7, set SDA_OE=0 and go to ACK_RISE.
    - Otherwise shift left by 1, increment bit_cnt, and go to DRIVE.
  - ACK_RISE: on `rise`, set ACK = ~sda_s and go to ACK_FALL.
  - ACK_FALL: on `fall`, go to FINISH.
  - FINISH: pulse DONE, then go to IDLE.
- ABORT in any non-IDLE state: SDA_OE=0 on the next edge, go to IDLE, no DONE, ACK unchanged. ABORT has priority over every edge event in the same cycle.
- LOAD and ABORT together in IDLE: LOAD is taken and ABORT is ignored.
- LOAD while not IDLE: OVERRUN=1 for one cycle; shift register and state are unchanged.
- `rise` in DRIVE is treated as a protocol violation: the responder proceeds to WAIT_FALL anyway, with data already driven.
- bit_cnt is 3 bits and never wraps: exactly 8 data bits go out per LOAD.

## Timing
- Accepted LOAD at edge n, SCLK low: BUSY=1 and state DRIVE at n+1, SDA_OE valid at n+2.
- Pin edge to `rise`/`fall` pulse: SYNC_STAGES+1 CLK cycles.
- SCLK falling edge to SDA_OE update: SYNC_STAGES+3 cycles, comfortably inside the I2C tHD;DAT budget when CLK ≥ 20× SCLK.
- Required SCLK high/low phases: at least SYNC_STAGES+4 CLK periods each. Shorter phases are unsupported.
- 9th SCLK falling edge to DONE: SYNC_STAGES+3 cycles. BUSY drops one cycle after DONE.
- RST_N assertion mid-transfer: SDA_OE drops to 0 asynchronously, releasing the bus immediately.

## Structure
- Shared package `i2c_defs.v`: state index constants (IDLE..FINISH), SYNC_STAGES default, and the SDA_OE polarity macro. The existing `define.v` include and SIM state-name strings go in the package as well.
- One sub-module, `i2c_sync_edge`: synchronizer plus rise/fall pulse generator, instantiated twice (SCLK, SDA). Edge outputs are unused for SDA.

## Test plan
- DIN=8'hA5, SCLK 100 kHz from CLK 50 MHz, controller ACKs → SDA sampled on rising edges reads 1,0,1,0,0,1,0,1; SDA_OE=0 during the 9th clock; DONE pulses once; ACK=1.
- DIN=8'h00, controller NACKs (SDA high on 9th rise) → eight low bits sampled, ACK=0, DONE pulses once.
- LOAD with SCLK already high, DIN=8'hFF → SDA_OE stays 0 until the first falling edge; all 8 bits are released high; DONE pulses.
- LOAD 8'h3C, second LOAD 8'hC3 during bit 4 → OVERRUN pulses once; transmitted byte is still 3C; DONE pulses once.
- ABORT asserted after bit 2 of 8'h80 → SDA_OE=0 on the next cycle, BUSY=0, no DONE; a fresh LOAD 8'h81 then transmits correctly.
- RST_N low during bit 5 with SDA_OE=1 → SDA_OE goes 0 with no CLK edge; all outputs hold reset values until RST_N rises.

Source files
------------

// File: rtl/i2c_byte_responder_pkg.sv
// Shared constants for the I2C byte responder: one-hot state indices,
// synchronizer depth default, byte/counter widths and SDA drive polarity.
package i2c_byte_responder_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned N_STATES        = 8;

  localparam int unsigned S_IDLE      = 0;
  localparam int unsigned S_WAIT_LOW  = 1;
  localparam int unsigned S_DRIVE     = 2;
  localparam int unsigned S_WAIT_RISE = 3;
  localparam int unsigned S_WAIT_FALL = 4;
  localparam int unsigned S_ACK_RISE  = 5;
  localparam int unsigned S_ACK_FALL  = 6;
  localparam int unsigned S_FINISH    = 7;

  typedef logic [N_STATES-1:0] state_t;

  localparam state_t ST_IDLE      = state_t'(1 << S_IDLE);
  localparam state_t ST_WAIT_LOW  = state_t'(1 << S_WAIT_LOW);
  localparam state_t ST_DRIVE     = state_t'(1 << S_DRIVE);
  localparam state_t ST_WAIT_RISE = state_t'(1 << S_WAIT_RISE);
  localparam state_t ST_WAIT_FALL = state_t'(1 << S_WAIT_FALL);
  localparam state_t ST_ACK_RISE  = state_t'(1 << S_ACK_RISE);
  localparam state_t ST_ACK_FALL  = state_t'(1 << S_ACK_FALL);
  localparam state_t ST_FINISH    = state_t'(1 << S_FINISH);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Open-drain pad: enable pulls the line low, disable releases it
  localparam logic OE_PULL    = 1'b1;
  localparam logic OE_RELEASE = 1'b0;

endpackage

// File: rtl/i2c_byte_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus line, with registered
// single-cycle rise/fall pulses derived from the synchronized level.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  assign level = chain[STAGES-1];

  // Pulses are registered, so a pin edge shows up STAGES+1 cycles later
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chain <= '0;
      hist  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      hist  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~hist;
      fall  <= ~chain[STAGES-1] & hist;
    end
  end

endmodule

// File: rtl/i2c_byte_responder.sv
// Target-side I2C read responder: shifts one byte out MSB-first on an
// open-drain SDA, then samples the controller's ACK/NACK on the 9th clock.
module i2c_byte_responder
  import i2c_byte_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LOAD,
  input  logic [DATA_W-1:0] DIN,
  input  logic              ABORT,
  input  logic              SCLK_IN,
  input  logic              SDA_IN,
  output logic              SDA_OE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ACK,
  output logic              OVERRUN
);

  logic sclk_s;
  logic sclk_rise;
  logic sclk_fall;
  logic sda_s;
  logic sda_rise_unused;
  logic sda_fall_unused;
  logic unused_sda_edges;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nxt;
  logic              sda_oe_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              ack_nxt;
  logic              overrun_nxt;
  logic              abort_hit;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .async_in (SCLK_IN),
    .level    (sclk_s),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .async_in (SDA_IN),
    .level    (sda_s),
    .rise     (sda_rise_unused),
    .fall     (sda_fall_unused)
  );

  // Only the SDA level is consumed; its edge pulses are left dangling
  assign unused_sda_edges = sda_rise_unused | sda_fall_unused;

  assign abort_hit = ABORT & ~state[S_IDLE];

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      SDA_OE  <= OE_RELEASE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ACK     <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      SDA_OE  <= sda_oe_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
      ACK     <= ack_nxt;
      OVERRUN <= overrun_nxt;
    end
  end

  // Next-state logic; ABORT outranks every SCLK event outside IDLE
  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = ST_IDLE;
    end else begin
      case (1'b1)
        state[S_IDLE]: begin
          if (LOAD) state_nxt = sclk_s ? ST_WAIT_LOW : ST_DRIVE;
        end
        state[S_WAIT_LOW]: begin
          if (sclk_fall) state_nxt = ST_DRIVE;
        end
        state[S_DRIVE]: begin
          // A rise here is a protocol violation; data is already on the pad
          state_nxt = sclk_rise ? ST_WAIT_FALL : ST_WAIT_RISE;
        end
        state[S_WAIT_RISE]: begin
          if (sclk_rise) state_nxt = ST_WAIT_FALL;
        end
        state[S_WAIT_FALL]: begin
          if (sclk_fall) state_nxt = (bit_cnt == LAST_BIT) ? ST_ACK_RISE : ST_DRIVE;
        end
        state[S_ACK_RISE]: begin
          if (sclk_rise) state_nxt = ST_ACK_FALL;
        end
        state[S_ACK_FALL]: begin
          if (sclk_fall) state_nxt = ST_FINISH;
        end
        state[S_FINISH]: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    sda_oe_nxt  = SDA_OE;
    busy_nxt    = BUSY;
    done_nxt    = 1'b0;
    ack_nxt     = ACK;
    overrun_nxt = LOAD & ~state[S_IDLE];

    if (abort_hit) begin
      sda_oe_nxt = OE_RELEASE;
      busy_nxt   = 1'b0;
    end else begin
      case (1'b1)
        state[S_IDLE]: begin
          busy_nxt   = 1'b0;
          sda_oe_nxt = OE_RELEASE;
          if (LOAD) begin
            shift_nxt   = DIN;
            bit_cnt_nxt = '0;
            busy_nxt    = 1'b1;
          end
        end
        state[S_DRIVE]: begin
          sda_oe_nxt = shift[DATA_W-1] ? OE_RELEASE : OE_PULL;
        end
        state[S_WAIT_FALL]: begin
          if (sclk_fall) begin
            if (bit_cnt == LAST_BIT) begin
              sda_oe_nxt = OE_RELEASE;
            end else begin
              shift_nxt   = {shift[DATA_W-2:0], 1'b0};
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        state[S_ACK_RISE]: begin
          if (sclk_rise) ack_nxt = ~sda_s;
        end
        state[S_FINISH]: begin
          done_nxt = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
